bus_watchdog: RTL

Bus termination merger and cycle watchdog that sits directly downstream of the memory timing block. It ANDs the active-low termination strobes from the memory and I/O slaves onto the CPU bus, and asserts a bus error when a cycle that has begun goes unterminated for too long. It also captures the address-select context and a saturating count of timed-out cycles, so the monitor ROM can report stray accesses.

---
 rtl/bus_watchdog.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bus_watchdog.sv
// Bus termination merger: ANDs slave DSACK/STERM/BERR onto the CPU bus and
// raises a watchdog BERR when a started cycle stays unterminated too long.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       sysClk,
    input  logic       sysReset,
    input  logic       nAS,
    input  logic       addr31,
    input  logic [2:0] addrSel,
    input  logic       RnW,
    input  logic [1:0] nDsackMem,
    input  logic       nStermMem,
    input  logic       nBerrMem,
    input  logic [1:0] nDsackIo,
    input  logic       nStermIo,
    input  logic       nBerrIo,
    input  logic       faultClear,
    output logic [1:0] nDsack,
    output logic       nSterm,
    output logic       nBerr,
    output logic       timeoutFlag,
    output logic       conflictFlag,
    output logic [4:0] faultInfo,
    output logic [7:0] faultCount
);

    localparam int unsigned CountW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CtxW   = 5;
    localparam int unsigned FcntW  = 8;
    localparam logic [CountW-1:0] CountLast = CountW'(TIMEOUT - 1);
    localparam logic [FcntW-1:0]  FcntMax   = '1;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Active  = 2'd1,
        WaitNeg = 2'd2,
        Fault   = 2'd3
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [CountW-1:0]  count;
    logic [CountW-1:0]  countNext;
    logic [CtxW-1:0]    cycleCtx;
    logic               berrWd;
    logic               berrWdNext;
    logic               startCycle;
    logic               faultEvent;
    logic               conflictEvent;
    logic               memTerm;
    logic               ioTerm;
    logic               term;

    // Zero-latency merge keeps the slaves' clock-exact STERM timing intact
    assign nDsack = nDsackMem & nDsackIo;
    assign nSterm = nStermMem & nStermIo;
    assign nBerr  = nBerrMem & nBerrIo & berrWd;

    assign memTerm = ~(&nDsackMem) | ~nStermMem | ~nBerrMem;
    assign ioTerm  = ~(&nDsackIo)  | ~nStermIo  | ~nBerrIo;
    assign term    = memTerm | ioTerm;

    // State register
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state <= Idle;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; termination is checked ahead of the timeout compare
    always_comb begin
        stateNext = state;
        unique case (state)
            Idle:    if (!nAS) stateNext = Active;
            Active: begin
                if (nAS)                     stateNext = Idle;
                else if (term)               stateNext = WaitNeg;
                else if (count == CountLast) stateNext = Fault;
                else                         stateNext = Active;
            end
            WaitNeg: if (nAS) stateNext = Idle;
            Fault:   if (nAS) stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    // Output/datapath decode for the registered watchdog side
    always_comb begin
        startCycle    = 1'b0;
        faultEvent    = 1'b0;
        conflictEvent = 1'b0;
        countNext     = count;
        berrWdNext    = (stateNext != Fault);
        unique case (state)
            Idle: begin
                if (!nAS) begin
                    startCycle = 1'b1;
                    countNext  = '0;
                end
            end
            Active: begin
                conflictEvent = memTerm & ioTerm;
                if (!nAS && !term) begin
                    if (count == CountLast) faultEvent = 1'b1;
                    else                    countNext  = count + CountW'(1);
                end
            end
            default: ;
        endcase
    end

    // Counter, cycle context and watchdog BERR
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            count    <= '0;
            cycleCtx <= '0;
            berrWd   <= 1'b1;
        end else begin
            count  <= countNext;
            berrWd <= berrWdNext;
            if (startCycle) cycleCtx <= {addr31, RnW, addrSel};
        end
    end

    // Status capture; a fault or conflict in the clearing clock wins over the clear
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            timeoutFlag  <= 1'b0;
            conflictFlag <= 1'b0;
            faultInfo    <= '0;
            faultCount   <= '0;
        end else begin
            timeoutFlag  <= faultEvent | (timeoutFlag & ~faultClear);
            conflictFlag <= conflictEvent | (conflictFlag & ~faultClear);
            if (faultEvent) begin
                faultInfo <= cycleCtx;
                if (faultClear)                faultCount <= FcntW'(1);
                else if (faultCount != FcntMax) faultCount <= faultCount + FcntW'(1);
            end else if (faultClear) begin
                faultCount <= '0;
            end
        end
    end

endmodule
